// File: rtl/cw_capture_pkg.sv
// Shared definitions for the capture sequencer: state encoding and modulo-DEPTH
// address helpers used by the controller and its wrap counter.
package cw_capture_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } cw_state_t;

    function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
        return (a >= depth - 1) ? 32'd0 : a + 32'd1;
    endfunction

    // (a - b) mod depth, for a, b already in [0, depth)
    function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                             input int unsigned depth);
        return (a >= b) ? a - b : a + depth - b;
    endfunction

endpackage

// File: rtl/cw_capture_ctrl_if.sv
// Control, trigger and trace-RAM write-port bundle between the trigger engine,
// the capture sequencer and its readout logic.
interface cw_capture_ctrl_if #(parameter int ADDR_W = 16);
    logic              arm;
    logic              abort;
    logic [ADDR_W-1:0] cfg_pre;
    logic              trig_hit;
    logic              st_qual;
    logic              wt_ce;
    logic              wt_en;
    logic [ADDR_W-1:0] wt_addr;
    logic              busy;
    logic              triggered;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] start_addr;

    modport master (
        input  arm, abort, cfg_pre, trig_hit, st_qual,
        output wt_ce, wt_en, wt_addr, busy, triggered, done, trig_addr, start_addr
    );

    modport slave (
        output arm, abort, cfg_pre, trig_hit, st_qual,
        input  wt_ce, wt_en, wt_addr, busy, triggered, done, trig_addr, start_addr
    );
endinterface

// File: rtl/cw_wrap_cnt.sv
// Modulo-DEPTH counter with synchronous clear and increment enable; clear wins.
module cw_wrap_cnt
    import cw_capture_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 1024
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rstn || clr)
            cnt <= '0;
        else if (inc)
            cnt <= W'(wrap_inc(32'(cnt), DEPTH));
    end

endmodule

// File: rtl/cw_capture_ctrl.sv
// Trace-buffer capture sequencer: circular pre-trigger fill, trigger wait, post fill.
// Optional storage qualification is enabled by defining CW_STORAGE_QUAL_EN.
module cw_capture_ctrl
    import cw_capture_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic             trig_clk,
    input  logic             trig_rstn,
    cw_capture_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] PRE_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

    cw_state_t         state, state_n;
    logic [ADDR_W-1:0] pre_q, pre_n, pre_cnt, trig_addr, start_addr, wt_addr, trig_src;
    logic [ADDR_W:0]   post_cnt, post_tgt;
    logic              wt_ce, wt_en, busy, done, triggered, trig_pend;
    logic              wt_ce_n, wt_en_n, done_n;
    logic              qual, wr, arm_ok, trig_take, pre_last, post_last, to_done;

`ifdef CW_STORAGE_QUAL_EN
    assign qual = bus.st_qual;
`else
    logic unused_st_qual;
    assign unused_st_qual = bus.st_qual;
    assign qual           = 1'b1;
`endif

    // wt_en is the write taking place in the current cycle
    assign wr        = wt_en;
    assign arm_ok    = bus.arm && !bus.abort && (state == IDLE || state == DONE);
    assign pre_n     = (bus.cfg_pre > PRE_MAX) ? PRE_MAX : bus.cfg_pre;
    assign post_tgt  = DEPTH_X - {1'b0, pre_q};
    assign trig_take = (state == WAIT) && wr && (bus.trig_hit || trig_pend);
    assign pre_last  = (state == PRE) && wr && (pre_cnt + ADDR_W'(1) == pre_q);
    assign post_last = (state == POST) && wr && (post_cnt + (ADDR_W+1)'(1) == post_tgt);
    assign to_done   = (state_n == DONE) && (state != DONE);
    assign trig_src  = trig_take ? wt_addr : trig_addr;

    always_ff @(posedge trig_clk) begin
        if (!trig_rstn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bus.abort)
            state_n = IDLE;
        else begin
            case (state)
                IDLE, DONE: if (bus.arm) state_n = (pre_n == '0) ? WAIT : PRE;
                PRE:        if (pre_last) state_n = WAIT;
                // with pre = DEPTH-1 the trigger sample is the only post sample
                WAIT:       if (trig_take)
                                state_n = (post_tgt == (ADDR_W+1)'(1)) ? DONE : POST;
                POST:       if (post_last) state_n = DONE;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        wt_ce_n = (state_n == PRE) || (state_n == WAIT) || (state_n == POST);
        wt_en_n = wt_ce_n && qual;
        done_n  = (state_n == DONE);
    end

    always_ff @(posedge trig_clk) begin
        if (!trig_rstn) begin
            wt_ce <= 1'b0;
            wt_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            wt_ce <= wt_ce_n;
            wt_en <= wt_en_n;
            busy  <= wt_ce_n;
            done  <= done_n;
        end
    end

    always_ff @(posedge trig_clk) begin
        if (!trig_rstn) begin
            pre_q      <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            triggered  <= 1'b0;
            trig_pend  <= 1'b0;
        end else if (bus.abort) begin
            trig_pend  <= 1'b0;
        end else if (arm_ok) begin
            pre_q      <= pre_n;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            triggered  <= 1'b0;
            trig_pend  <= 1'b0;
        end else begin
            if (state == PRE && wr)
                pre_cnt <= pre_cnt + ADDR_W'(1);
            if (state == POST && wr)
                post_cnt <= post_cnt + (ADDR_W+1)'(1);
            // a trigger seen on an unqualified cycle waits for the next stored sample
            if (trig_take) begin
                trig_addr <= wt_addr;
                triggered <= 1'b1;
                post_cnt  <= (ADDR_W+1)'(1);
                trig_pend <= 1'b0;
            end else if (state == WAIT && bus.trig_hit) begin
                trig_pend <= 1'b1;
            end
            if (to_done)
                start_addr <= ADDR_W'(wrap_sub(32'(trig_src), 32'(pre_q), DEPTH));
        end
    end

    cw_wrap_cnt #(.W(ADDR_W), .DEPTH(DEPTH)) u_addr (
        .clk  (trig_clk),
        .rstn (trig_rstn),
        .clr  (arm_ok),
        .inc  (wr && !bus.abort),
        .cnt  (wt_addr)
    );

    assign bus.wt_ce      = wt_ce;
    assign bus.wt_en      = wt_en;
    assign bus.wt_addr    = wt_addr;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.triggered  = triggered;
    assign bus.trig_addr  = trig_addr;
    assign bus.start_addr = start_addr;

endmodule
